// File: rtl/pipe_ctrl_if.sv
// Datapath <-> sequencing-controller bundle: hazard/memory status in, pipeline-register controls out.
// master = controller side, slave = datapath side.
interface pipe_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic       ex_reg_write;
  logic [4:0] ex_rw;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_flush;
  logic       exmem_en;
  logic       memwb_flush;

  modport master (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_mem_read, ex_reg_write, ex_rw, ex_branch_taken,
    input  mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush
  );

  modport slave (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_mem_read, ex_reg_write, ex_rw, ex_branch_taken,
    output mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: load-use bubbles, branch flushes, memory freeze with timeout, stall counter.
// Controls are combinational (0-cycle); state/mem_err/stall_count update one edge later.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  pipe_ctrl_if.master      bus,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mwait;
  logic lu;
  logic br;
  logic rs_hit;
  logic rt_hit;

  assign mwait  = bus.mem_req & ~bus.mem_ready;
  assign rs_hit = bus.id_uses_rs & (bus.id_rs == bus.ex_rw);
  assign rt_hit = bus.id_uses_rt & (bus.id_rt == bus.ex_rw);
  assign lu     = bus.ex_mem_read & bus.ex_reg_write & (bus.ex_rw != 5'd0) & (rs_hit | rt_hit);
  assign br     = bus.ex_branch_taken;

  // Control decode: reset > ERR > memory freeze > branch flush > load-use bubble.
  always_comb begin
    bus.pc_en       = 1'b1;
    bus.ifid_en     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_en     = 1'b1;
    bus.idex_flush  = 1'b0;
    bus.exmem_en    = 1'b1;
    bus.memwb_flush = 1'b0;
    if (reset) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.memwb_flush = 1'b1;
    end else if (state_q == ERR || mwait) begin
      bus.pc_en       = 1'b0;
      bus.ifid_en     = 1'b0;
      bus.idex_en     = 1'b0;
      bus.exmem_en    = 1'b0;
      bus.memwb_flush = 1'b1;
    end else if (br) begin
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (lu) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.idex_flush = 1'b1;
    end
  end

  // Next state; a ready in the final wait cycle beats the timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      RUN: begin
        if (mwait) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = ERR;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!bus.pc_en && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state       = state_q;
  assign mem_err     = mem_err_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl (MEM_TIMEOUT=4, CNT_W=4): directed table, hand sequences, random vs reference model.
module tb_pipe_ctrl;
  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  // control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
  localparam logic [6:0] V_RST = 7'b1111111;
  localparam logic [6:0] V_FRZ = 7'b0000001;
  localparam logic [6:0] V_BR  = 7'b1111110;
  localparam logic [6:0] V_LU  = 7'b0001110;
  localparam logic [6:0] V_RUN = 7'b1101010;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mrd;
    logic       rwe;
    logic [4:0] rw;
    logic       br;
    logic       mreq;
    logic       mrdy;
  } in_t;

  typedef struct {
    in_t        i;
    logic [6:0] ctl;
    logic [1:0] st;
    int         cnt;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    state;
  logic          mem_err;
  logic [CW-1:0] stall_count;
  int            errors = 0;
  int            checks = 0;

  // reference model state: mode 0=running 1=waiting 2=failed
  int m_mode = 0;
  int m_waited = 0;
  bit m_err = 1'b0;
  int m_stalls = 0;

  pipe_ctrl_if pif();

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .bus(pif),
    .state(state), .mem_err(mem_err), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  function automatic in_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                             logic mrd, logic rwe, logic [4:0] rw, logic br, logic mreq, logic mrdy);
    in_t x;
    x = '{rst, rs, rt, urs, urt, mrd, rwe, rw, br, mreq, mrdy};
    return x;
  endfunction

  function automatic logic [6:0] m_ctl(in_t x);
    bit hazard;
    hazard = x.mrd && x.rwe && (x.rw != 0) &&
             ((x.urs && x.rs == x.rw) || (x.urt && x.rt == x.rw));
    if (x.rst) return V_RST;
    if (m_mode == 2 || (x.mreq && !x.mrdy)) return V_FRZ;
    if (x.br) return V_BR;
    if (hazard) return V_LU;
    return V_RUN;
  endfunction

  function automatic logic [6:0] dut_ctl();
    return {pif.pc_en, pif.ifid_en, pif.ifid_flush, pif.idex_en, pif.idex_flush,
            pif.exmem_en, pif.memwb_flush};
  endfunction

  task automatic drive(in_t x);
    reset               = x.rst;
    pif.id_rs           = x.rs;
    pif.id_rt           = x.rt;
    pif.id_uses_rs      = x.urs;
    pif.id_uses_rt      = x.urt;
    pif.ex_mem_read     = x.mrd;
    pif.ex_reg_write    = x.rwe;
    pif.ex_rw           = x.rw;
    pif.ex_branch_taken = x.br;
    pif.mem_req         = x.mreq;
    pif.mem_ready       = x.mrdy;
    #1;
  endtask

  // Advance one clock edge, updating the model from the cycle's inputs.
  task automatic tick(in_t x);
    logic [6:0] c;
    c = m_ctl(x);
    if (x.rst) begin
      m_mode = 0; m_waited = 0; m_err = 1'b0; m_stalls = 0;
    end else begin
      if (!c[6] && m_stalls < SAT) m_stalls++;
      if (m_mode == 0 && x.mreq && !x.mrdy) begin
        m_mode = 1; m_waited = 1;
      end else if (m_mode == 1) begin
        if (x.mrdy) begin
          m_mode = 0; m_waited = 0;
        end else if (m_waited == TO - 1) begin
          m_mode = 2; m_err = 1'b1;
        end else begin
          m_waited++;
        end
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [6:0] ectl, logic [1:0] est, logic eerr, int ecnt);
    chk({tag, ".ctl"}, int'(dut_ctl()), int'(ectl));
    chk({tag, ".state"}, int'(state), int'(est));
    chk({tag, ".mem_err"}, int'(mem_err), int'(eerr));
    chk({tag, ".stall_count"}, int'(stall_count), ecnt);
  endtask

  in_t  RST, IDLE, LU5, MW, MRDY;
  vec_t tbl[$];

  initial begin
    RST  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    IDLE = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    LU5  = mk(0, 5, 0, 1, 0, 1, 1, 5, 0, 0, 0);
    MW   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    MRDY = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    tbl.push_back('{RST,  V_RST, 2'b00, 0});
    tbl.push_back('{LU5,  V_LU,  2'b00, 0});
    tbl.push_back('{IDLE, V_RUN, 2'b00, 1});
    tbl.push_back('{mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0), V_RUN, 2'b00, 1});
    tbl.push_back('{mk(0, 0, 7, 0, 0, 1, 1, 7, 0, 0, 0), V_RUN, 2'b00, 1});
    tbl.push_back('{mk(0, 0, 7, 0, 1, 1, 1, 7, 0, 0, 0), V_LU,  2'b00, 1});
    tbl.push_back('{mk(0, 0, 7, 0, 1, 1, 1, 7, 1, 0, 0), V_BR,  2'b00, 2});
    tbl.push_back('{mk(0, 5, 0, 1, 0, 1, 0, 5, 0, 0, 0), V_RUN, 2'b00, 2});
    tbl.push_back('{MW,   V_FRZ, 2'b00, 2});
    tbl.push_back('{MW,   V_FRZ, 2'b01, 3});
    tbl.push_back('{mk(0, 5, 0, 1, 0, 1, 1, 5, 1, 1, 0), V_FRZ, 2'b01, 4});
    tbl.push_back('{MRDY, V_RUN, 2'b01, 5});
    tbl.push_back('{IDLE, V_RUN, 2'b00, 5});
    tbl.push_back('{MRDY, V_RUN, 2'b00, 5});
    tbl.push_back('{IDLE, V_RUN, 2'b00, 5});

    @(negedge clock);
    drive(RST); tick(RST);

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      check_all($sformatf("tbl%0d", k), tbl[k].ctl, tbl[k].st, 1'b0, tbl[k].cnt);
      tick(tbl[k].i);
    end

    // Timeout: four wait cycles then ERR, frozen until reset clears everything.
    drive(RST); tick(RST);
    for (int k = 0; k < TO; k++) begin
      drive(MW);
      check_all($sformatf("to_wait%0d", k), V_FRZ, (k == 0) ? 2'b00 : 2'b01, 1'b0, k);
      tick(MW);
    end
    drive(IDLE);
    check_all("to_err0", V_FRZ, 2'b10, 1'b1, 4);
    tick(IDLE);
    drive(IDLE);
    check_all("to_err1", V_FRZ, 2'b10, 1'b1, 5);
    drive(RST);
    chk("to_rst.ctl", int'(dut_ctl()), int'(V_RST));
    tick(RST);
    drive(IDLE);
    check_all("to_after_rst", V_RUN, 2'b00, 1'b0, 0);
    tick(IDLE);

    // Ready arriving on the cycle the timeout would fire.
    drive(RST); tick(RST);
    for (int k = 0; k < TO - 1; k++) begin
      drive(MW); tick(MW);
    end
    drive(MRDY);
    check_all("race_rdy", V_RUN, 2'b01, 1'b0, 3);
    tick(MRDY);
    drive(IDLE);
    check_all("race_after", V_RUN, 2'b00, 1'b0, 3);
    tick(IDLE);

    // Stall counter saturation.
    drive(RST); tick(RST);
    for (int k = 0; k < 20; k++) begin
      drive(LU5); tick(LU5);
    end
    drive(IDLE);
    check_all("sat", V_RUN, 2'b00, 1'b0, SAT);
    tick(IDLE);

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      in_t x;
      x.rst  = ($urandom_range(0, 39) == 0);
      x.rs   = 5'($urandom_range(0, 3));
      x.rt   = 5'($urandom_range(0, 3));
      x.urs  = 1'($urandom);
      x.urt  = 1'($urandom);
      x.mrd  = 1'($urandom);
      x.rwe  = ($urandom_range(0, 3) != 0);
      x.rw   = 5'($urandom_range(0, 3));
      x.br   = ($urandom_range(0, 4) == 0);
      x.mreq = ($urandom_range(0, 2) == 0);
      x.mrdy = ($urandom_range(0, 2) == 0);
      drive(x);
      check_all($sformatf("rnd%0d", n), m_ctl(x), 2'(m_mode), m_err, m_stalls);
      tick(x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
